// File: rtl/mem_access_unit.sv
// Data-memory access stage for the RV32I datapath: issues one word-aligned load or store,
// captures the read word in the MDR and hands word, byte offset and funct3 to load extraction.
module mem_access_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] addr,
    input  logic [width-1:0] wdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [width-1:0] mem_address,
    output logic [width-1:0] mem_wdata,
    output logic [3:0]       mem_byte_enable,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic [width-1:0] mdr_out,
    output logic [1:0]       sel_out,
    output logic [2:0]       funct3_out,
    output logic             done,
    output logic             fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t           state;
    logic             legal_f3;
    logic             misaligned;
    logic [3:0]       lane_mask;
    logic [width-1:0] lane_data;

    // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        lane_data  = wdata << {addr[1:0], 3'b000};

        unique case (funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = !req_write;
            default:                legal_f3 = 1'b0;
        endcase

        if (funct3[1:0] == 2'b01 && addr[0])
            misaligned = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            misaligned = 1'b1;

        unique case (funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << addr[1:0];
            2'b01:   lane_mask = 4'b0011 << addr[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    assign req_ready = (state == IDLE);

    // Strobes, lanes and the done/fault pulses are all registered: no request or memory
    // input reaches an output combinationally.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= 4'b0000;
            mdr_out         <= '0;
            sel_out         <= 2'b00;
            funct3_out      <= 3'b000;
            done            <= 1'b0;
            fault           <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal_f3 || misaligned) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            sel_out     <= addr[1:0];
                            funct3_out  <= funct3;
                            mem_address <= {addr[width-1:2], 2'b00};
                            if (req_write) begin
                                state           <= WRITE;
                                mem_write       <= 1'b1;
                                mem_byte_enable <= lane_mask;
                                mem_wdata       <= lane_data;
                            end else begin
                                state           <= READ;
                                mem_read        <= 1'b1;
                                mem_byte_enable <= 4'b0000;
                            end
                        end
                    end
                end

                READ: begin
                    if (mem_resp) begin
                        mdr_out  <= mem_rdata;
                        mem_read <= 1'b0;
                        done     <= 1'b1;
                        state    <= RESP;
                    end
                end

                WRITE: begin
                    if (mem_resp) begin
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    strobe_exclusive: assert property (@(posedge clk) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written multi-cycle sequences and
// random transactions checked against a behavioural access model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [31:0] mdr_out;
    logic [1:0]  sel_out;
    logic [2:0]  funct3_out;
    logic        done;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_mdr;
    logic [1:0]  exp_sel;
    logic [2:0]  exp_f3;

    mem_access_unit #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mdr_out(mdr_out), .sel_out(sel_out), .funct3_out(funct3_out),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        logic        flt;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Access rules written as plain arithmetic over size and byte offset.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic flt, output logic [31:0] x_addr,
                         output logic [3:0] x_be, output logic [31:0] x_wd);
        int size;
        int ofs;
        bit legal;
        ofs = int'(a % 4);
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size   = 1 << f3[1:0];
        flt    = !legal || ((a % size) != 0);
        x_addr = a - ofs;
        x_be   = wr ? 4'(((1 << size) - 1) << ofs) : 4'b0000;
        x_wd   = wd << (8 * ofs);
    endtask

    task automatic run_txn(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int dly, input logic x_flt, input logic [31:0] x_addr,
                           input logic [3:0] x_be, input logic [31:0] x_wd);
        @(negedge clk);
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        req_valid = 1'b0;
        addr      = $urandom;
        if (x_flt) begin
            check({name, "_fault"}, 32'(fault), 32'd1);
            check({name, "_nostrobe"}, 32'({mem_read, mem_write}), 32'd0);
            check({name, "_mdr_hold"}, mdr_out, exp_mdr);
            check({name, "_sel_hold"}, 32'(sel_out), 32'(exp_sel));
            check({name, "_f3_hold"}, 32'(funct3_out), 32'(exp_f3));
            @(negedge clk);
            check({name, "_fault_end"}, 32'(fault), 32'd0);
            check({name, "_idle"}, 32'(req_ready), 32'd1);
        end else begin
            exp_sel = a[1:0];
            exp_f3  = f3;
            for (int i = 1; i <= dly; i++) begin
                check({name, "_rd_strobe"}, 32'(mem_read), 32'(!wr));
                check({name, "_wr_strobe"}, 32'(mem_write), 32'(wr));
                check({name, "_addr"}, mem_address, x_addr);
                check({name, "_be"}, 32'(mem_byte_enable), 32'(x_be));
                if (wr) check({name, "_wdata"}, mem_wdata, x_wd);
                check({name, "_early_done"}, 32'(done), 32'd0);
                if (i == dly) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rd;
                end
                @(negedge clk);
            end
            mem_resp  = 1'b0;
            mem_rdata = $urandom;
            if (!wr) exp_mdr = rd;
            check({name, "_strobe_off"}, 32'({mem_read, mem_write}), 32'd0);
            check({name, "_done"}, 32'(done), 32'd1);
            check({name, "_mdr"}, mdr_out, exp_mdr);
            check({name, "_sel"}, 32'(sel_out), 32'(exp_sel));
            check({name, "_f3"}, 32'(funct3_out), 32'(exp_f3));
            @(negedge clk);
            check({name, "_done_end"}, 32'(done), 32'd0);
            check({name, "_idle"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic        r_wr, r_flt;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_wd, r_xa, r_xwd;
        logic [3:0]  r_xbe;

        vecs[0] = '{"lw_100",    1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'h100, 4'b0000, 32'h0};
        vecs[1] = '{"sb_203",    1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        1, 1'b0, 32'h200, 4'b1000, 32'hA5000000};
        vecs[2] = '{"sh_102",    1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        2, 1'b0, 32'h100, 4'b1100, 32'h12340000};
        vecs[3] = '{"lh_101",    1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[4] = '{"lw_102",    1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[5] = '{"ld_f3_011", 1'b0, 3'b011, 32'h040, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[6] = '{"st_f3_100", 1'b1, 3'b100, 32'h040, 32'h0,        32'h0,        1, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[7] = '{"lbu_007",   1'b0, 3'b100, 32'h007, 32'h0,        32'h11223344, 2, 1'b0, 32'h004, 4'b0000, 32'h0};
        vecs[8] = '{"sw_010",    1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0,        4, 1'b0, 32'h010, 4'b1111, 32'hCAFEF00D};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_resp = 1'b0;
        exp_mdr = 32'h0; exp_sel = 2'b00; exp_f3 = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_pulses", 32'({done, fault}), 32'd0);
        check("rst_be", 32'(mem_byte_enable), 32'd0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_sel_f3", 32'({sel_out, funct3_out}), 32'd0);

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                    vecs[i].dly, vecs[i].flt, vecs[i].x_addr, vecs[i].x_be, vecs[i].x_wd);

        // Back-to-back LBU 0x3 then SW 0x8 with req_valid held; stray mem_resp in RESP/IDLE.
        @(negedge clk);
        check("b2b_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b100; addr = 32'h3;
        @(negedge clk);
        check("b2b_busy1", 32'(req_ready), 32'd0);
        check("b2b_read", 32'(mem_read), 32'd1);
        check("b2b_raddr", mem_address, 32'h0);
        req_write = 1'b1; funct3 = 3'b010; addr = 32'h8; wdata = 32'h89ABCDEF;
        mem_resp = 1'b1; mem_rdata = 32'h000000C3;
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_mdr1", mdr_out, 32'h000000C3);
        check("b2b_sel1", 32'(sel_out), 32'd3);
        check("b2b_f3_1", 32'(funct3_out), 32'd4);
        check("b2b_busy2", 32'(req_ready), 32'd0);
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("b2b_idle", 32'(req_ready), 32'd1);
        check("b2b_nodone", 32'(done), 32'd0);
        check("b2b_sel_hold", 32'(sel_out), 32'd3);
        check("b2b_mdr_hold", mdr_out, 32'h000000C3);
        check("b2b_nowrite", 32'(mem_write), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; mem_resp = 1'b0;
        check("b2b_write", 32'(mem_write), 32'd1);
        check("b2b_waddr", mem_address, 32'h8);
        check("b2b_wbe", 32'(mem_byte_enable), 32'hF);
        check("b2b_wdata", mem_wdata, 32'h89ABCDEF);
        check("b2b_sel2", 32'(sel_out), 32'd0);
        check("b2b_f3_2", 32'(funct3_out), 32'd2);
        check("b2b_mdr_keep", mdr_out, 32'h000000C3);
        check("b2b_no_early", 32'(done), 32'd0);
        @(negedge clk);
        check("b2b_write_held", 32'(mem_write), 32'd1);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_write_off", 32'(mem_write), 32'd0);
        exp_mdr = 32'h000000C3; exp_sel = 2'b00; exp_f3 = 3'b010;

        // Reset while an LW awaits mem_resp; a late response must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_strobe", 32'(mem_read), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_mdr", mdr_out, 32'h0);
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_resp = 1'b0;
        check("rstmid_nodone", 32'(done), 32'd0);
        check("rstmid_mdr_keep", mdr_out, 32'h0);
        check("rstmid_nostrobe", 32'({mem_read, mem_write}), 32'd0);
        exp_mdr = 32'h0; exp_sel = 2'b00; exp_f3 = 3'b000;

        for (int i = 0; i < 60; i++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            r_wd = $urandom;
            model(r_wr, r_f3, r_a, r_wd, r_flt, r_xa, r_xbe, r_xwd);
            run_txn($sformatf("rnd%0d", i), r_wr, r_f3, r_a, r_wd, $urandom,
                    $urandom_range(1, 4), r_flt, r_xa, r_xbe, r_xwd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
